// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the elastic pipeline register.
// Holds the stage-count upper bound and the COUNT width helper.
package pipe_pkg;

  localparam int MAX_DEPTH = 8;

  // Bits needed to represent 0..depth valid stages.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one pipeline slot (data register + valid bit).
// Ports: clk, rst, flush, adv (load enable), din/vin (upstream), dout/vout.
module pipe_stage #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  // Flush only drops the valid bit; the data register keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VALUE;
      vout <= 1'b0;
    end else if (flush) begin
      vout <= 1'b0;
    end else if (adv) begin
      dout <= din;
      vout <= vin;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready pipeline with bubble collapse.
// Ports: CLOCK, RESET, FLUSH, IN_VALID/IN_READY/D, OUT_VALID/OUT_READY/Q, COUNT.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [WIDTH-1:0]           D,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_reg: DEPTH out of range 1..8");
  end

  logic [DEPTH:0]   adv;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vin;
  logic [DEPTH-1:0] nv;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  logic [CW-1:0]    pop;
  logic [CW-1:0]    cnt_q;

  // A stage advances when it is empty or its
  // successor advances; the tail sees OUT_READY.
  // nv is each stage's valid bit after the edge.
  always_comb begin
    adv        = '0;
    vin        = '0;
    nv         = '0;
    pop        = '0;
    adv[DEPTH] = OUT_READY;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = !vld[k] | adv[k+1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 0) begin
        vin[k] = IN_VALID;
        din[k] = D;
      end else begin
        vin[k] = vld[k-1];
        din[k] = dat[k-1];
      end
      nv[k] = !FLUSH & (adv[k] ? vin[k] : vld[k]);
      pop   = pop + CW'(nv[k]);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (CLOCK),
      .rst   (RESET),
      .flush (FLUSH),
      .adv   (adv[k]),
      .din   (din[k]),
      .vin   (vin[k]),
      .dout  (dat[k]),
      .vout  (vld[k])
    );
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= pop;
  end

  assign IN_READY  = adv[0];
  assign OUT_VALID = vld[DEPTH-1];
  assign Q         = dat[DEPTH-1];
  assign COUNT     = cnt_q;

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: random + directed bench for pipe_reg (DEPTH=3 and DEPTH=1).
// Reference is a queue of in-flight entries, each tagged with its position.
module tb_pipe_reg;

  localparam int          W    = 32;
  localparam logic [31:0] RV0  = 32'hDEAD_BEEF;
  localparam int          DEP [2] = '{3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst [2];
  logic         fl  [2];
  logic         iv  [2];
  logic         ir  [2];
  logic         ov  [2];
  logic         orr [2];
  logic [W-1:0] dd  [2];
  logic [W-1:0] qq  [2];
  logic [1:0]   cnt0;
  logic [0:0]   cnt1;

  pipe_reg #(.WIDTH(W), .DEPTH(3), .RESET_VALUE(RV0)) u_dut0 (
    .CLOCK(clk), .RESET(rst[0]), .FLUSH(fl[0]),
    .IN_VALID(iv[0]), .IN_READY(ir[0]), .D(dd[0]),
    .OUT_VALID(ov[0]), .OUT_READY(orr[0]), .Q(qq[0]),
    .COUNT(cnt0)
  );

  pipe_reg #(.WIDTH(W), .DEPTH(1)) u_dut1 (
    .CLOCK(clk), .RESET(rst[1]), .FLUSH(fl[1]),
    .IN_VALID(iv[1]), .IN_READY(ir[1]), .D(dd[1]),
    .OUT_VALID(ov[1]), .OUT_READY(orr[1]), .Q(qq[1]),
    .COUNT(cnt1)
  );

  // Model: entries ordered oldest first; mp = stage index.
  logic [31:0] md  [2][8];
  int          mp  [2][8];
  int          msz [2];
  bit          mv  [2][8];
  bit          mir [2];
  bit          started [2];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int i,
                              logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] got %h want %h at %0t",
               nm, i, act, exp, $time);
    end
  endfunction

  // An entry moves if it leaves via OUT_READY, or the
  // slot ahead is free, or the entry ahead also moves.
  function automatic void calc(int i);
    for (int e = 0; e < msz[i]; e++) begin
      if (mp[i][e] == DEP[i] - 1)
        mv[i][e] = orr[i];
      else if (e == 0)
        mv[i][e] = 1'b1;
      else
        mv[i][e] = (mp[i][e-1] != mp[i][e] + 1) || mv[i][e-1];
    end
    mir[i] = (msz[i] == 0) || (mp[i][msz[i]-1] != 0)
          || mv[i][msz[i]-1];
  endfunction

  function automatic void step(int i);
    int n;
    bit acc;
    if (rst[i] === 1'b1) begin
      msz[i]     = 0;
      started[i] = 1'b1;
      return;
    end
    if (!started[i]) return;
    calc(i);
    acc = iv[i] && mir[i] && !fl[i];
    if (fl[i]) begin
      msz[i] = 0;
      return;
    end
    n = 0;
    for (int e = 0; e < msz[i]; e++) begin
      if (!(mp[i][e] == DEP[i] - 1 && mv[i][e])) begin
        md[i][n] = md[i][e];
        mp[i][n] = mp[i][e] + (mv[i][e] ? 1 : 0);
        n++;
      end
    end
    if (acc) begin
      md[i][n] = dd[i];
      mp[i][n] = 0;
      n++;
    end
    msz[i] = n;
  endfunction

  always @(posedge clk) begin
    step(0);
    step(1);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (started[i]) begin
        bit eov;
        calc(i);
        eov = (msz[i] > 0) && (mp[i][0] == DEP[i] - 1);
        chk("m_out_valid", i, 32'(ov[i]), 32'(eov));
        chk("m_in_ready", i, 32'(ir[i]), 32'(mir[i]));
        chk("m_count", i,
            (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(msz[i]));
        if (eov) chk("m_q", i, qq[i], md[i][0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rstc(int i);
    rst[i] = 1'b1;
    cyc();
    rst[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; fl[i] = 1'b0; iv[i] = 1'b0;
      orr[i] = 1'b0; dd[i] = '0;
      started[i] = 1'b0; msz[i] = 0;
    end
    cyc();
    cyc();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk("rst_q", 0, qq[0], RV0);
    chk("rst_ov", 0, 32'(ov[0]), 0);
    chk("rst_cnt", 0, 32'(cnt0), 0);
    chk("rst_ir", 0, 32'(ir[0]), 1);
    chk("rst_q", 1, qq[1], 0);

    // Streaming: Q=1 three edges after the first transfer.
    orr[0] = 1'b1; iv[0] = 1'b1;
    dd[0] = 1; cyc();
    chk("s1_lat_ov", 0, 32'(ov[0]), 0);
    dd[0] = 2; cyc();
    dd[0] = 3; cyc();
    chk("s1_ov", 0, 32'(ov[0]), 1);
    chk("s1_q1", 0, qq[0], 1);
    dd[0] = 4; cyc();
    chk("s1_q2", 0, qq[0], 2);
    iv[0] = 1'b0; cyc();
    chk("s1_q3", 0, qq[0], 3);
    cyc();
    chk("s1_q4", 0, qq[0], 4);
    cyc();
    chk("s1_end", 0, 32'(ov[0]), 0);

    // Fill / backpressure.
    orr[0] = 1'b0; iv[0] = 1'b1;
    dd[0] = 32'hA; cyc();
    dd[0] = 32'hB; cyc();
    dd[0] = 32'hC; cyc();
    chk("s2_ir", 0, 32'(ir[0]), 0);
    chk("s2_cnt", 0, 32'(cnt0), 3);
    dd[0] = 32'hD; cyc();
    chk("s2_hold_cnt", 0, 32'(cnt0), 3);
    chk("s2_qa", 0, qq[0], 32'hA);
    orr[0] = 1'b1; cyc();
    iv[0] = 1'b0;
    chk("s2_qb", 0, qq[0], 32'hB);
    cyc();
    chk("s2_qc", 0, qq[0], 32'hC);
    cyc();
    chk("s2_qd", 0, qq[0], 32'hD);
    cyc();
    chk("s2_end", 0, 32'(ov[0]), 0);

    // Bubble collapse.
    rstc(0);
    orr[0] = 1'b0;
    iv[0] = 1'b1; dd[0] = 32'h11; cyc();
    iv[0] = 1'b0; cyc();
    iv[0] = 1'b1; dd[0] = 32'h22; cyc();
    chk("s3_cnt2", 0, 32'(cnt0), 2);
    chk("s3_ir", 0, 32'(ir[0]), 1);
    dd[0] = 32'h33; cyc();
    iv[0] = 1'b0;
    chk("s3_cnt3", 0, 32'(cnt0), 3);

    // Flush of a full pipe with a simultaneous push.
    rstc(0);
    iv[0] = 1'b1;
    dd[0] = 32'h5; cyc();
    dd[0] = 32'h6; cyc();
    dd[0] = 32'h7; cyc();
    fl[0] = 1'b1; dd[0] = 32'h8; cyc();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("s4_ov", 0, 32'(ov[0]), 0);
    chk("s4_cnt", 0, 32'(cnt0), 0);
    orr[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("s4_no8", 0, 32'(ov[0]), 0);
    end

    // Reset together with flush, two entries in flight.
    orr[0] = 1'b0; iv[0] = 1'b1;
    dd[0] = 32'h1; cyc();
    dd[0] = 32'h2; cyc();
    iv[0] = 1'b0;
    rst[0] = 1'b1; fl[0] = 1'b1; cyc();
    rst[0] = 1'b0; fl[0] = 1'b0;
    chk("s5_q", 0, qq[0], RV0);
    chk("s5_ov", 0, 32'(ov[0]), 0);
    chk("s5_cnt", 0, 32'(cnt0), 0);
    chk("s5_ir", 0, 32'(ir[0]), 1);

    // DEPTH=1: latency of one edge, full after one accept.
    orr[1] = 1'b1; iv[1] = 1'b1;
    dd[1] = 32'h1; cyc();
    chk("d1_ov", 1, 32'(ov[1]), 1);
    chk("d1_q1", 1, qq[1], 1);
    dd[1] = 32'h2; cyc();
    chk("d1_q2", 1, qq[1], 2);
    iv[1] = 1'b0; cyc();
    chk("d1_end", 1, 32'(ov[1]), 0);
    orr[1] = 1'b0; iv[1] = 1'b1;
    dd[1] = 32'hA; cyc();
    dd[1] = 32'hB;
    chk("d1_ir", 1, 32'(ir[1]), 0);
    chk("d1_cnt", 1, 32'(cnt1), 1);
    cyc();
    iv[1] = 1'b0;
    chk("d1_hold", 1, qq[1], 32'hA);

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 199) == 0);
        fl[i]  = ($urandom_range(0, 59) == 0);
        iv[i]  = ($urandom_range(0, 3) != 0);
        orr[i] = ((n / 150) % 2 == 0)
               ? ($urandom_range(0, 9) < 8)
               : ($urandom_range(0, 9) < 3);
        dd[i]  = $urandom;
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; fl[i] = 1'b0; iv[i] = 1'b0;
    end
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the data width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 3, as the number of pipeline stages; legal range is 1..8.
REQ-003 The block SHALL take parameter RESET_VALUE, default WIDTH'h0, as the data value loaded into every stage on reset.
REQ-004 The block SHALL have port CLOCK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port FLUSH, input, 1 bit: synchronous invalidate of all stages.
REQ-007 The block SHALL have port IN_VALID, input, 1 bit: the producer offers D.
REQ-008 The block SHALL have port IN_READY, output, 1 bit: stage 0 can accept this cycle.
REQ-009 The block SHALL have port D, input, WIDTH bits: input data.
REQ-010 The block SHALL have port OUT_VALID, output, 1 bit: Q holds valid data.
REQ-011 The block SHALL have port OUT_READY, input, 1 bit: the consumer accepts Q this cycle.
REQ-012 The block SHALL have port Q, output, WIDTH bits: the data of the last stage (DEPTH-1).
REQ-013 The block SHALL have port COUNT, output, $clog2(DEPTH+1) bits: the number of valid stages.

Function
REQ-014 Each stage k SHALL hold data_k[WIDTH] and valid_k; stage 0 is the input end and stage DEPTH-1 drives Q and OUT_VALID.
REQ-015 The advance signal adv_k SHALL be !valid_k OR adv_(k+1); adv_DEPTH is defined as OUT_READY.
REQ-016 IN_READY SHALL equal adv_0, computed combinationally and independent of IN_VALID.
REQ-017 On each edge where adv_k is 1, stage k SHALL load the data and valid bit of stage k-1; stage 0 loads D and IN_VALID.
REQ-018 When adv_k is 0, stage k SHALL hold its data and valid bit.
REQ-019 Bubbles SHALL collapse: when a downstream stage holds valid data and is stalled, an empty upstream stage still accepts data.
REQ-020 An input transfer occurs when IN_VALID and IN_READY are both 1; an output transfer occurs when OUT_VALID and OUT_READY are both 1.
REQ-021 Latency through an empty pipe with OUT_READY held at 1 SHALL be DEPTH edges from input transfer to OUT_VALID=1.
REQ-022 Throughput with OUT_READY held at 1 SHALL be one word per cycle, including when the pipe is full.
REQ-023 With OUT_READY=0, the pipe SHALL fill to DEPTH entries; IN_READY SHALL then be 0 and COUNT SHALL equal DEPTH.
REQ-024 Data SHALL leave in input order, with no loss and no duplication.
REQ-025 FLUSH=1 SHALL clear all valid_k at the edge and discard any input transfer in that cycle; data registers hold their values.
REQ-026 During a FLUSH cycle, an output transfer SHALL still count as consumed by the consumer.
REQ-027 COUNT SHALL be registered and equal the population count of valid_k after each edge; it SHALL read 0 after FLUSH or RESET.
REQ-028 When OUT_VALID=0, Q SHALL show the held data_(DEPTH-1) value, and that value SHALL be treated as don't-care.

Reset
REQ-029 RESET SHALL take priority over FLUSH and over all transfers.
REQ-030 On RESET at an edge, every valid_k, OUT_VALID and COUNT SHALL be 0, and every data_k and Q SHALL equal RESET_VALUE.
REQ-031 When RESET is asserted mid-stream, in-flight data SHALL be dropped; IN_READY SHALL read 1 from the first cycle after reset.

Structure
REQ-032 Shared package pipe_pkg SHALL hold the DEPTH upper bound constant (8) and a count-width helper function.
REQ-033 One sub-module, pipe_stage, SHALL implement a single stage (data register, valid bit, adv input, RESET and FLUSH).
REQ-034 pipe_reg SHALL instantiate pipe_stage DEPTH times in a generate loop and add the adv chain and the COUNT logic.

Verification (WIDTH=32, DEPTH=3)
REQ-035 Streaming: apply RESET, then IN_VALID=1 with D=1,2,3,4 on consecutive cycles and OUT_READY=1 -> Q=1 appears with OUT_VALID=1 three edges after the first input transfer, then 2,3,4 on consecutive cycles.
REQ-036 Fill/backpressure: OUT_READY=0, push 0xA,0xB,0xC,0xD -> IN_READY drops after 3 accepts, COUNT=3 and 0xD is not accepted; raise OUT_READY -> output sequence is 0xA,0xB,0xC,0xD.
REQ-037 Bubble collapse: push 0x11, idle one cycle, push 0x22 with OUT_READY=0 -> COUNT=2 and IN_READY=1; one more push gives COUNT=3.
REQ-038 Flush: with pipe full (0x5,0x6,0x7), assert FLUSH and IN_VALID with D=0x8 for one cycle -> next cycle OUT_VALID=0, COUNT=0, and 0x8 never appears at Q.
REQ-039 Reset mid-stream: with RESET_VALUE=0xDEAD_BEEF and 2 entries in flight, assert RESET together with FLUSH -> Q=0xDEADBEEF, OUT_VALID=0, COUNT=0, IN_READY=1.
REQ-040 DEPTH=1 build: run scenarios 1 and 2 -> latency is 1 edge and the pipe fills after 1 accept.
